// File: rtl/axi4_lite_Defs.sv
// Shared AXI4-Lite definitions: bus widths, response codes, FSM state types
// and the address-to-word-index helper used by the slave decode.
package axi4_lite_Defs;

   localparam int unsigned Addr_Width = 32;
   localparam int unsigned Data_Width = 32;
   localparam int unsigned Strb_Width = Data_Width / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_A, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

   // Word index relative to the window base; the byte offset bits drop out in the shift.
   function automatic logic [Addr_Width-1:0] word_index(input logic [Addr_Width-1:0] addr,
                                                        input logic [Addr_Width-1:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_slave_if;
   import axi4_lite_Defs::*;

   logic [Addr_Width-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [Data_Width-1:0] WDATA;
   logic [Strb_Width-1:0] WSTRB;
   logic                  WVALID;
   logic                  WREADY;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;
   logic [Addr_Width-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [Data_Width-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

endinterface

// File: rtl/axi4_lite_regfile.sv
// Depth x 32-bit register file: async clear, one byte-strobed write port,
// one combinational read port.
module axi4_lite_regfile
   import axi4_lite_Defs::*;
#(
   parameter int unsigned Depth = 16
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     we,
   input  logic [((Depth > 1) ? $clog2(Depth) : 1)-1:0] waddr,
   input  logic [Data_Width-1:0]                    wdata,
   input  logic [Strb_Width-1:0]                    wstrb,
   input  logic [((Depth > 1) ? $clog2(Depth) : 1)-1:0] raddr,
   output logic [Data_Width-1:0]                    rdata
);

   logic [Data_Width-1:0] mem [Depth];

   // Storage: cleared by reset, byte lanes written where the strobe is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int unsigned b = 0; b < Strb_Width; b++) begin
            if (wstrb[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave over a byte-strobed register file. Independent write and
// read FSMs; accesses outside the Depth-word window at Base_Addr get SLVERR.
module axi4_lite_slave
   import axi4_lite_Defs::*;
#(
   parameter int unsigned           Depth     = 16,
   parameter logic [Addr_Width-1:0] Base_Addr = '0
) (
   input logic              ACLK,
   input logic              ARESET,
   axi4_lite_slave_if.slave bus
);

   localparam int unsigned Idx_Width = (Depth > 1) ? $clog2(Depth) : 1;

   wr_state_t             wr_state;
   rd_state_t             rd_state;
   logic [Addr_Width-1:0] aw_addr_q;
   logic [Data_Width-1:0] w_data_q;
   logic [Strb_Width-1:0] w_strb_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic                  rvalid_q;
   logic [1:0]            rresp_q;
   logic [Data_Width-1:0] rdata_q;

   logic                  aw_hs, w_hs, ar_hs;
   logic                  wr_commit;
   logic [Addr_Width-1:0] wr_addr;
   logic [Data_Width-1:0] wr_data;
   logic [Strb_Width-1:0] wr_strb;
   logic [Addr_Width-1:0] wr_word, rd_word;
   logic                  wr_ok, rd_ok;
   logic [Data_Width-1:0] mem_rdata;

   // Readies decode the state; held low while reset is asserted.
   assign bus.AWREADY = !ARESET && (wr_state == WR_IDLE || wr_state == WR_WAIT_A);
   assign bus.WREADY  = !ARESET && (wr_state == WR_IDLE || wr_state == WR_WAIT_W);
   assign bus.ARREADY = !ARESET && (rd_state == RD_IDLE);

   assign bus.BVALID = bvalid_q;
   assign bus.BRESP  = bresp_q;
   assign bus.RVALID = rvalid_q;
   assign bus.RRESP  = rresp_q;
   assign bus.RDATA  = rdata_q;

   assign aw_hs = bus.AWVALID && bus.AWREADY;
   assign w_hs  = bus.WVALID && bus.WREADY;
   assign ar_hs = bus.ARVALID && bus.ARREADY;

   // Pick address/data from the bus or the latched half, and flag the commit edge.
   always_comb begin
      wr_commit = 1'b0;
      wr_addr   = bus.AWADDR;
      wr_data   = bus.WDATA;
      wr_strb   = bus.WSTRB;
      case (wr_state)
         WR_IDLE:   wr_commit = aw_hs && w_hs;
         WR_WAIT_W: begin
            wr_commit = w_hs;
            wr_addr   = aw_addr_q;
         end
         WR_WAIT_A: begin
            wr_commit = aw_hs;
            wr_data   = w_data_q;
            wr_strb   = w_strb_q;
         end
         default:   wr_commit = 1'b0;
      endcase
   end

   assign wr_word = word_index(wr_addr, Base_Addr);
   assign wr_ok   = (wr_addr >= Base_Addr) && (wr_word < Addr_Width'(Depth));
   assign rd_word = word_index(bus.ARADDR, Base_Addr);
   assign rd_ok   = (bus.ARADDR >= Base_Addr) && (rd_word < Addr_Width'(Depth));

   axi4_lite_regfile #(
      .Depth (Depth)
   ) u_regfile (
      .clk   (ACLK),
      .rst   (ARESET),
      .we    (wr_commit && wr_ok),
      .waddr (wr_word[Idx_Width-1:0]),
      .wdata (wr_data),
      .wstrb (wr_strb),
      .raddr (rd_word[Idx_Width-1:0]),
      .rdata (mem_rdata)
   );

   // Write FSM: collect AW and W in either order, then hold the response until BREADY.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_state  <= WR_IDLE;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (wr_state)
            WR_IDLE: begin
               if (wr_commit) begin
                  wr_state <= WR_RESP;
               end else if (aw_hs) begin
                  aw_addr_q <= bus.AWADDR;
                  wr_state  <= WR_WAIT_W;
               end else if (w_hs) begin
                  w_data_q <= bus.WDATA;
                  w_strb_q <= bus.WSTRB;
                  wr_state <= WR_WAIT_A;
               end
            end
            WR_WAIT_W, WR_WAIT_A: begin
               if (wr_commit) wr_state <= WR_RESP;
            end
            WR_RESP: begin
               if (bus.BREADY) begin
                  bvalid_q <= 1'b0;
                  wr_state <= WR_IDLE;
               end
            end
            default: wr_state <= WR_IDLE;
         endcase
         // Commit never occurs in WR_RESP, so this cannot collide with the BREADY clear.
         if (wr_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Read FSM: capture data on AR handshake, hold it until RREADY.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rd_state <= RD_IDLE;
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (ar_hs) begin
                  rdata_q  <= rd_ok ? mem_rdata : '0;
                  rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                  rvalid_q <= 1'b1;
                  rd_state <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (bus.RREADY) begin
                  rvalid_q <= 1'b0;
                  rd_state <= RD_IDLE;
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Randomised self-checking bench for axi4_lite_slave against a word-array model.
module tb_axi4_lite_slave;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0;

   logic ACLK   = 1'b0;
   logic ARESET = 1'b1;
   int   total  = 0;
   int   bad    = 0;

   logic [31:0] model_mem [DEPTH];

   axi4_lite_slave_if bus ();

   axi4_lite_slave #(
      .Depth     (DEPTH),
      .Base_Addr (BASE)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   always #5 ACLK = ~ACLK;

   // ---------------- reference model ----------------
   function automatic bit m_in_range(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) / 4) < 32'(DEPTH));
   endfunction

   function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d,
                                          input logic [3:0] s);
      int idx;
      if (!m_in_range(a)) return 2'b10;
      idx = int'((a - BASE) / 4);
      for (int b = 0; b < 4; b++) begin
         if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
      end
      return 2'b00;
   endfunction

   function automatic logic [31:0] m_read_data(input logic [31:0] a);
      if (!m_in_range(a)) return 32'h0;
      return model_mem[int'((a - BASE) / 4)];
   endfunction

   function automatic logic [1:0] m_resp(input logic [31:0] a);
      return m_in_range(a) ? 2'b00 : 2'b10;
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
   endfunction

   // ---------------- bus drivers ----------------
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic idle_bus();
      bus.AWADDR = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b0;
      bus.ARADDR = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] resp, output int b_lat,
                            output bit to);
      int cyc;
      bit aw_done, w_done, aw_fire, w_fire;
      cyc = 0; aw_done = 0; w_done = 0; to = 0; resp = 2'b11; b_lat = 0;
      bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb; bus.BREADY = 1'b0;
      while (!(aw_done && w_done) && cyc < 50) begin
         bus.AWVALID = !aw_done && (cyc >= aw_dly);
         bus.WVALID  = !w_done && (cyc >= w_dly);
         aw_fire = bus.AWVALID && bus.AWREADY;
         w_fire  = bus.WVALID && bus.WREADY;
         tick();
         cyc++;
         aw_done |= aw_fire;
         w_done  |= w_fire;
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      if (!(aw_done && w_done)) begin
         to = 1;
         return;
      end
      while (!bus.BVALID && b_lat < 20) begin
         tick();
         b_lat++;
      end
      if (!bus.BVALID) begin
         to = 1;
         return;
      end
      repeat (b_dly) tick();
      resp = bus.BRESP;
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat, output bit to);
      int cyc;
      cyc = 0; to = 0; lat = 0; data = 32'hx; resp = 2'bx;
      bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
      while (!bus.ARREADY && cyc < 50) begin
         tick();
         cyc++;
      end
      if (!bus.ARREADY) begin
         bus.ARVALID = 1'b0;
         to = 1;
         return;
      end
      tick();
      bus.ARVALID = 1'b0;
      while (!bus.RVALID && lat < 20) begin
         tick();
         lat++;
      end
      if (!bus.RVALID) begin
         to = 1;
         return;
      end
      data = bus.RDATA;
      resp = bus.RRESP;
      bus.RREADY = 1'b1;
      tick();
      bus.RREADY = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_bus();
      ARESET = 1'b1;
      m_clear();
      tick(); tick();
      total++;
      if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b000) begin
         bad++; $display("FAIL reset_readies got=%b want=000",
                         {bus.AWREADY, bus.WREADY, bus.ARREADY});
      end
      total++;
      if ({bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP} !== 6'b0) begin
         bad++; $display("FAIL reset_valids_resps got=%b want=000000",
                         {bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP});
      end
      total++;
      if (bus.RDATA !== 32'h0) begin
         bad++; $display("FAIL reset_rdata got=%h want=00000000", bus.RDATA);
      end
      ARESET = 1'b0;
      #1;
      total++;
      if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
         bad++; $display("FAIL post_reset_readies got=%b want=111",
                         {bus.AWREADY, bus.WREADY, bus.ARREADY});
      end
   endtask

   task automatic test_aw_w_same();
      logic [1:0] resp, er; logic [31:0] d; int lat; bit to;
      er = m_write(32'h8, 32'hDEADBEEF, 4'hF);
      axi_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, lat, to);
      total++;
      if (to || lat != 0 || resp !== er) begin
         bad++; $display("FAIL same_cycle_write to=%0d lat=%0d resp=%b want lat=0 resp=%b",
                         to, lat, resp, er);
      end
      axi_read(32'h8, d, resp, lat, to);
      total++;
      if (to || lat != 0 || d !== m_read_data(32'h8) || resp !== 2'b00) begin
         bad++; $display("FAIL same_cycle_readback to=%0d lat=%0d data=%h resp=%b want %h/00",
                         to, lat, d, resp, m_read_data(32'h8));
      end
   endtask

   task automatic test_aw_first();
      logic [1:0] resp, er; logic [31:0] d; int lat; bit to;
      bus.AWADDR = 32'h4; bus.AWVALID = 1'b1;
      tick();
      bus.AWVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b010) begin
            bad++; $display("FAIL wait_w_readies cyc=%0d got=%b want=010", i,
                            {bus.AWREADY, bus.WREADY, bus.BVALID});
         end
         tick();
      end
      bus.WDATA = 32'h11223344; bus.WSTRB = 4'b0101; bus.WVALID = 1'b1;
      tick();
      bus.WVALID = 1'b0;
      er = m_write(32'h4, 32'h11223344, 4'b0101);
      total++;
      if (bus.BVALID !== 1'b1 || bus.BRESP !== er) begin
         bad++; $display("FAIL aw_first_bresp bvalid=%b bresp=%b want 1/%b",
                         bus.BVALID, bus.BRESP, er);
      end
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
      axi_read(32'h4, d, resp, lat, to);
      total++;
      if (to || d !== m_read_data(32'h4) || resp !== 2'b00) begin
         bad++; $display("FAIL aw_first_strobe_merge to=%0d data=%h want=%h", to, d,
                         m_read_data(32'h4));
      end
   endtask

   task automatic test_w_first_bstall();
      logic [1:0] resp, er; logic [31:0] d; int lat; bit to;
      bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
      tick();
      bus.WVALID = 1'b0;
      total++;
      if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b100) begin
         bad++; $display("FAIL wait_a_readies got=%b want=100",
                         {bus.AWREADY, bus.WREADY, bus.BVALID});
      end
      bus.AWADDR = 32'h10; bus.AWVALID = 1'b1;
      tick();
      bus.AWVALID = 1'b0;
      er = m_write(32'h10, 32'hCAFEF00D, 4'hF);
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY} !== {1'b1, er, 2'b00}) begin
            bad++; $display("FAIL bstall cyc=%0d got=%b want=%b", i,
                            {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY},
                            {1'b1, er, 2'b00});
         end
         tick();
      end
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
      total++;
      if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011) begin
         bad++; $display("FAIL bstall_release got=%b want=011",
                         {bus.BVALID, bus.AWREADY, bus.WREADY});
      end
      axi_read(32'h10, d, resp, lat, to);
      total++;
      if (to || d !== m_read_data(32'h10)) begin
         bad++; $display("FAIL w_first_readback data=%h want=%h", d, m_read_data(32'h10));
      end
   endtask

   task automatic test_out_of_range();
      logic [1:0] resp; logic [31:0] d; int lat; bit to;
      axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, lat, to);
      total++;
      if (to || resp !== m_write(32'h40, 32'hFFFFFFFF, 4'hF)) begin
         bad++; $display("FAIL oor_write to=%0d resp=%b want=10", to, resp);
      end
      axi_read(32'h44, d, resp, lat, to);
      total++;
      if (to || d !== 32'h0 || resp !== m_resp(32'h44)) begin
         bad++; $display("FAIL oor_read to=%0d data=%h resp=%b want 00000000/10", to, d, resp);
      end
      for (int i = 0; i < DEPTH; i++) begin
         axi_read(32'(i * 4), d, resp, lat, to);
         total++;
         if (to || d !== model_mem[i] || resp !== 2'b00) begin
            bad++; $display("FAIL oor_mem_intact word=%0d data=%h want=%h", i, d, model_mem[i]);
         end
      end
   endtask

   task automatic test_collision();
      logic [1:0] resp; logic [31:0] d, old; int lat; bit to;
      old = m_read_data(32'hC);
      bus.AWADDR = 32'hC; bus.AWVALID = 1'b1;
      bus.WDATA = 32'h5A5A5A5A; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      bus.ARADDR = 32'hC; bus.ARVALID = 1'b1;
      bus.RREADY = 1'b0; bus.BREADY = 1'b0;
      tick();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      void'(m_write(32'hC, 32'h5A5A5A5A, 4'hF));
      total++;
      if (bus.RVALID !== 1'b1 || bus.BVALID !== 1'b1 || bus.RDATA !== old) begin
         bad++; $display("FAIL collision rvalid=%b bvalid=%b rdata=%h want 1/1/%h",
                         bus.RVALID, bus.BVALID, bus.RDATA, old);
      end
      bus.RREADY = 1'b1; bus.BREADY = 1'b1;
      tick();
      bus.RREADY = 1'b0; bus.BREADY = 1'b0;
      axi_read(32'hC, d, resp, lat, to);
      total++;
      if (to || d !== m_read_data(32'hC)) begin
         bad++; $display("FAIL collision_after data=%h want=%h", d, m_read_data(32'hC));
      end
   endtask

   task automatic test_random();
      logic [1:0] resp, er; logic [31:0] a, d, wd; logic [3:0] s; int lat; bit to;
      for (int n = 0; n < 60; n++) begin
         a = 32'($urandom_range(0, 4 * DEPTH + 15));
         if ($urandom_range(0, 1) == 1) begin
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            er = m_write(a, wd, s);
            axi_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), resp, lat, to);
            total++;
            if (to || lat != 0 || resp !== er) begin
               bad++; $display("FAIL rand_write n=%0d addr=%h to=%0d lat=%0d resp=%b want=%b",
                               n, a, to, lat, resp, er);
            end
         end else begin
            axi_read(a, d, resp, lat, to);
            total++;
            if (to || lat != 0 || d !== m_read_data(a) || resp !== m_resp(a)) begin
               bad++; $display("FAIL rand_read n=%0d addr=%h data=%h resp=%b want=%h/%b",
                               n, a, d, resp, m_read_data(a), m_resp(a));
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      logic [1:0] resp; logic [31:0] d; int lat; bit to;
      bus.AWADDR = 32'h8; bus.AWVALID = 1'b1;
      bus.ARADDR = 32'h8; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
      tick();
      bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
      total++;
      if ({bus.AWREADY, bus.WREADY, bus.RVALID} !== 3'b011) begin
         bad++; $display("FAIL midflight_setup got=%b want=011",
                         {bus.AWREADY, bus.WREADY, bus.RVALID});
      end
      ARESET = 1'b1;
      #1;
      m_clear();
      total++;
      if ({bus.RVALID, bus.BVALID, bus.AWREADY} !== 3'b000 || bus.RDATA !== 32'h0) begin
         bad++; $display("FAIL midflight_async got=%b rdata=%h want=000/00000000",
                         {bus.RVALID, bus.BVALID, bus.AWREADY}, bus.RDATA);
      end
      tick(); tick();
      ARESET = 1'b0;
      #1;
      // A W now must not pair with the address that was latched before reset.
      bus.WDATA = 32'h77777777; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      tick();
      bus.WVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1) begin
            bad++; $display("FAIL midflight_no_commit cyc=%0d bvalid=%b awready=%b want 0/1",
                            i, bus.BVALID, bus.AWREADY);
         end
         tick();
      end
      for (int i = 0; i < DEPTH; i++) begin
         axi_read(32'(i * 4), d, resp, lat, to);
         total++;
         if (to || d !== model_mem[i]) begin
            bad++; $display("FAIL midflight_mem_cleared word=%0d data=%h want=%h",
                            i, d, model_mem[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_aw_w_same();
      test_aw_first();
      test_w_first_bstall();
      test_out_of_range();
      test_collision();
      test_random();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so a stuck handshake cannot hang the run.
   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
